bus_arbiter: RTL
================

# bus_arbiter

Round-robin arbiter and sequencer for the shared 12-bit processor data bus. Up to NUM_REQ requesters (core control units, DMA) each ask for one bus transfer and name a source code. The block grants the bus to one requester at a time, drives the bus multiplexer select, and holds it for the source's latency. It sits between the requesters and the `selectIn` input of the bus multiplexer, and is the only driver of that select.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MEM_LAT`, 2: extra cycles a DMem source must stay selected, 0..7.
- `SEL_WIDTH`, 4: bus select code width.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `req` input NUM_REQ: per-requester transfer request, level.
- `req_sel` input NUM_REQ*SEL_WIDTH: source code of requester i in bits [i*SEL_WIDTH +: SEL_WIDTH].
- `gnt` output NUM_REQ: one-hot grant, registered.
- `selectIn` output SEL_WIDTH: bus multiplexer select, registered.
- `done` output NUM_REQ: one-cycle pulse on the final bus cycle of requester i's transfer.
- `busy` output 1: high while any grant is active.
- `sel_err` output 1: sticky, set on an illegal source code, cleared only by reset.

## Operation
- Source codes: DMem 0, R 1, IR 2, RL 3, RC 4, RP 5, RQ 6, R1 7, AC 8, idle 9. Codes 10..15 are illegal.
- States:
  - IDLE: no grant, `selectIn`=9.
  - XFER: grant active, source selected.
  - MEMWAIT: DMem source held for MEM_LAT further cycles.
- Arbitration runs when the state is IDLE, or when the current transfer is in its final cycle.
  - The winner is the first asserted `req` at or after `rr_ptr`, searching upward and wrapping at NUM_REQ-1 to 0.
  - The winner's `req_sel` is captured into `cur_sel`. `gnt` and `selectIn` load on the next edge.
- `rr_ptr` becomes (winner+1) mod NUM_REQ at each grant. Reset value is 0.
- A transfer from a non-DMem source lasts 1 XFER cycle.
- A transfer from DMem lasts 1 XFER cycle plus MEM_LAT MEMWAIT cycles. `selectIn`=0 throughout. With MEM_LAT=0 it is a single XFER cycle.
- `done[i]` is high exactly on the final cycle. The destination latches the bus at the end of that cycle.
- A requester must hold `req` until its `done`. Dropping `req` mid-transfer does not abort the transfer. The currently granted requester's own `req` is ignored during its final cycle.
- Illegal code:
  - The grant is issued for 1 cycle with `selectIn`=9, `done` is pulsed, and `sel_err` is set.
  - Code 9 (idle) is legal: 1 cycle, `selectIn`=9.
- `busy` = |gnt.

## Timing
- Reset values: `gnt`=0, `selectIn`=9, `done`=0, `busy`=0, `sel_err`=0, state IDLE, `rr_ptr`=0. These are applied asynchronously, including mid-transfer. The aborted transfer produces no `done`.
- Latency from `req` rising (sampled at edge E, state IDLE) to `gnt` is 1 cycle: `gnt` is valid after edge E+1.
- Back-to-back grants have no idle cycle. The next winner's `gnt` and `selectIn` follow the previous final cycle directly.
- Simultaneous requests: exactly one grant per arbitration. Losers keep waiting. With all requests held, every requester is served within NUM_REQ grants.
- `req_sel` changing during a grant has no effect; only `cur_sel` drives `selectIn`.

## Configuration
- `BUS_ARB_PRIO0_EN`
  - Defined: requester 0 wins any arbitration in which `req[0]` is high. Its grant does not update `rr_ptr`. The others remain round-robin among themselves.
  - Undefined: pure round-robin as above.
- Ports are identical in both builds.

## Structure
- Shared package `bus_pkg`: the source-code constants (DMem_sel..idle), the state enum, and REG_WIDTH/INS_WIDTH.
- One sub-module, `rr_picker`, is combinational. It takes `req`, `rr_ptr`, and the priority enable, and produces a one-hot winner and a valid flag. It is instantiated once.

## Test plan
- Reset then idle: `selectIn`=9 and `gnt`=0. Assert `rst` mid-MEMWAIT -> the same values immediately, with no `done`.
- `req[2]`=1 with `req_sel[2]`=5 -> one cycle later `gnt`=4'b0100 and `selectIn`=5 for 1 cycle, `done[2]` in that cycle, then IDLE.
- `req[1]` with DMem (0), MEM_LAT=2 -> `selectIn`=0 for 3 cycles and `done[1]` on the 3rd only. Repeat with MEM_LAT=0 -> 1 cycle.
- All 4 requesting continuously with code 8 -> grant order 0,1,2,3,0, with no gaps. With `BUS_ARB_PRIO0_EN` -> 0 every cycle while `req[0]` is held.
- `req[3]` with code 12 -> 1 cycle `selectIn`=9, `done[3]` pulse, and `sel_err`=1 sticky.
- `req[0]` drops during MEMWAIT -> the transfer still completes. Then `req[1]`, already waiting, is granted the next cycle.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared constants and types for the processor data bus arbiter.
// Bus source-select codes, arbiter state encoding and datapath widths.
package bus_pkg;

  localparam int unsigned REG_WIDTH = 12;
  localparam int unsigned INS_WIDTH = 16;
  localparam int unsigned CNT_WIDTH = 3;

  localparam int unsigned DMEM_SEL = 0;
  localparam int unsigned R_SEL    = 1;
  localparam int unsigned IR_SEL   = 2;
  localparam int unsigned RL_SEL   = 3;
  localparam int unsigned RC_SEL   = 4;
  localparam int unsigned RP_SEL   = 5;
  localparam int unsigned RQ_SEL   = 6;
  localparam int unsigned R1_SEL   = 7;
  localparam int unsigned AC_SEL   = 8;
  localparam int unsigned IDLE_SEL = 9;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_XFER,
    ST_MEMWAIT
  } state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin winner selection with optional fixed priority for requester 0.
// Requests are rotated so rr_ptr sits at bit 0, the lowest set bit wins, then rotated back.
module rr_picker
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned PTR_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]   req,
  input  logic [PTR_WIDTH-1:0] rr_ptr,
  input  logic                 prio_en,
  output logic [NUM_REQ-1:0]   win,
  output logic                 valid
);

  logic [NUM_REQ-1:0] rot_req;
  logic [NUM_REQ-1:0] rot_win;
  logic               found;

  always_comb begin
    rot_req = NUM_REQ'({req, req} >> rr_ptr);
    rot_win = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rot_req[i] && !found) begin
        rot_win[i] = 1'b1;
        found      = 1'b1;
      end
    end
    win = NUM_REQ'(({rot_win, rot_win} << rr_ptr) >> NUM_REQ);
    if (prio_en && req[0]) begin
      win = NUM_REQ'(1);
    end
    valid = |req;
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin arbiter and sequencer driving the data bus multiplexer select.
// Define BUS_ARB_PRIO0_EN to give requester 0 fixed priority over the others.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned MEM_LAT   = 2,
  parameter int unsigned SEL_WIDTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*SEL_WIDTH-1:0]   req_sel,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [SEL_WIDTH-1:0]           selectIn,
  output logic [NUM_REQ-1:0]             done,
  output logic                           busy,
  output logic                           sel_err
);

  localparam int unsigned PTR_WIDTH = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef BUS_ARB_PRIO0_EN
  localparam logic PRIO0 = 1'b1;
`else
  localparam logic PRIO0 = 1'b0;
`endif

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PTR_WIDTH-1:0]   rr_ptr, ptr_d;
  logic [SEL_WIDTH-1:0]   cur_sel, cur_sel_d;
  logic [NUM_REQ-1:0]     gnt_d, done_d;
  logic                   busy_d, err_d;

  logic                   final_c;
  logic                   arb_c;
  logic [NUM_REQ-1:0]     keep_c;
  logic [NUM_REQ-1:0]     req_eff_c;
  logic [NUM_REQ-1:0]     win_c;
  logic                   win_valid_c;
  logic [PTR_WIDTH-1:0]   win_idx_c;
  logic [SEL_WIDTH-1:0]   win_code_c;

  // done is registered to mark the final bus cycle, so it doubles as the end-of-transfer flag
  assign final_c   = |done;
  assign arb_c     = (state_q == ST_IDLE) || final_c;
  assign keep_c    = PRIO0 ? NUM_REQ'(1) : '0;
  assign req_eff_c = req & ~(final_c ? (gnt & ~keep_c) : '0);
  assign selectIn  = cur_sel;

  rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .PTR_WIDTH (PTR_WIDTH)
  ) u_picker (
    .req     (req_eff_c),
    .rr_ptr  (rr_ptr),
    .prio_en (PRIO0),
    .win     (win_c),
    .valid   (win_valid_c)
  );

  // Encode the one-hot winner and fetch its source code
  always_comb begin
    win_idx_c  = '0;
    win_code_c = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_c[i]) begin
        win_idx_c  = PTR_WIDTH'(i);
        win_code_c = req_sel[i*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = rr_ptr;
    cur_sel_d = cur_sel;
    gnt_d     = gnt;
    done_d    = '0;
    err_d     = sel_err;
    if (arb_c) begin
      if (win_valid_c) begin
        state_d = ST_XFER;
        gnt_d   = win_c;
        done_d  = win_c;
        cnt_d   = '0;
        if (!(PRIO0 && (win_idx_c == '0))) begin
          ptr_d = (win_idx_c == PTR_WIDTH'(NUM_REQ - 1)) ? '0 : PTR_WIDTH'(win_idx_c + 1'b1);
        end
        if (win_code_c == SEL_WIDTH'(DMEM_SEL)) begin
          cur_sel_d = SEL_WIDTH'(DMEM_SEL);
          if (MEM_LAT != 0) begin
            done_d = '0;
            cnt_d  = CNT_WIDTH'(MEM_LAT);
          end
        end else if (win_code_c > SEL_WIDTH'(IDLE_SEL)) begin
          cur_sel_d = SEL_WIDTH'(IDLE_SEL);
          err_d     = 1'b1;
        end else begin
          cur_sel_d = win_code_c;
        end
      end else begin
        state_d   = ST_IDLE;
        gnt_d     = '0;
        cur_sel_d = SEL_WIDTH'(IDLE_SEL);
      end
    end else begin
      // DMem hold: count down remaining wait cycles, flag the last one
      state_d = ST_MEMWAIT;
      cnt_d   = cnt_q - CNT_WIDTH'(1);
      if (cnt_q == CNT_WIDTH'(1)) begin
        done_d = gnt;
      end
    end
    busy_d = |gnt_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rr_ptr  <= '0;
      cur_sel <= SEL_WIDTH'(IDLE_SEL);
      gnt     <= '0;
      done    <= '0;
      busy    <= 1'b0;
      sel_err <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rr_ptr  <= ptr_d;
      cur_sel <= cur_sel_d;
      gnt     <= gnt_d;
      done    <= done_d;
      busy    <= busy_d;
      sel_err <= err_d;
    end
  end

endmodule
